// File: rtl/dispatch_ctrl_pkg.sv
// Shared dispatch definitions: RV32I base opcodes (also used by the decoder),
// the class encoding for the issue target and the dispatch FSM encoding.
// Helper classify() maps an opcode to its target class and legality.
package dispatch_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        CLS_ROB = 2'd0,   // completes in the RoB, no execution unit
        CLS_RS  = 2'd1,
        CLS_LSB = 2'd2
    } cls_e;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    typedef struct packed {
        cls_e cls;
        logic illegal;
    } opc_info_t;

    // Unknown opcodes are routed RoB-only so the RoB can raise the exception.
    function automatic opc_info_t classify(input logic [6:0] op);
        opc_info_t r;
        r.cls     = CLS_ROB;
        r.illegal = 1'b0;
        case (op)
            OP_LOAD, OP_STORE:                 r.cls = CLS_LSB;
            OP_JALR, OP_BRANCH, OP_IMM, OP_OP: r.cls = CLS_RS;
            OP_LUI, OP_AUIPC, OP_JAL:          r.cls = CLS_ROB;
            default:                           r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// In-order dispatch queue of DEPTH entries, W bits wide.
// Ports: clk_in/rst_in (async active-low), en_i (global hold when low),
// clear_i (empties queue, wins over push/pop), push_i/wdata_i, pop_i,
// rdata_o (head entry, combinational), count_o (occupancy).
// Callers must not push when full nor pop when empty.
module dispatch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       en_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (en_i) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: reset empties the queue via the pointers.
    always_ff @(posedge clk_in) begin
        if (en_i && push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller between fetch and the decoder/issue fabric.
// Queues fetched {pc, instr}, classifies the head by opcode and issues it
// when the RoB and its target unit can both accept it, producing one-cycle
// issue strobes. Mispredict flush empties the queue for one FLUSH cycle.
// Ports: clk_in, rst_in (async active-low), rdy_in (global hold);
// fetch side if_valid/if_instr/if_pc/iq_ready; flush_in;
// back-pressure rob_full/rs_full/lsb_full; issue registers issue_valid,
// issue_instr, issue_pc, rob_issue, rs_issue, lsb_issue, rob_ready, illegal;
// stall_cnt saturating count of cycles with a blocked head.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc,
    output logic             iq_ready,
    input  logic             flush_in,
    input  logic             rob_full,
    input  logic             rs_full,
    input  logic             lsb_full,
    output logic             issue_valid,
    output logic [31:0]      issue_instr,
    output logic [31:0]      issue_pc,
    output logic             rob_issue,
    output logic             rs_issue,
    output logic             lsb_issue,
    output logic             rob_ready,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [0:0]       state_q, state_d;
    logic [AW:0]      count;
    logic [63:0]      head;
    logic [31:0]      head_instr, head_pc;
    opc_info_t        head_info;
    logic             unit_ok, run, nonempty, push, pop;

    logic             valid_q, rob_q, rs_q, lsb_q, rready_q, ill_q;
    logic [31:0]      instr_q, pc_q;
    logic [CNT_W-1:0] stall_q;

    assign head_instr = head[31:0];
    assign head_pc    = head[63:32];
    assign head_info  = classify(head_instr[6:0]);

    assign run      = (state_q == ST_RUN);
    assign nonempty = (count != '0);

    always_comb begin
        unit_ok = 1'b1;
        case (head_info.cls)
            CLS_RS:  unit_ok = !rs_full;
            CLS_LSB: unit_ok = !lsb_full;
            default: unit_ok = 1'b1;
        endcase
    end

    // No bypass: a full queue refuses even if the head pops this edge.
    assign iq_ready = rdy_in && run && (count < DEPTH_C);
    // Flush drops the offered instruction and blocks the pop.
    assign push = iq_ready && if_valid && !flush_in;
    assign pop  = rdy_in && run && nonempty && !rob_full && unit_ok && !flush_in;

    dispatch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .en_i    (rdy_in),
        .clear_i (flush_in),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({if_pc, if_instr}),
        .rdata_o (head),
        .count_o (count)
    );

    // FLUSH lasts one cycle unless flush_in stays high.
    assign state_d = flush_in ? ST_FLUSH : ST_RUN;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            rob_q    <= 1'b0;
            rs_q     <= 1'b0;
            lsb_q    <= 1'b0;
            rready_q <= 1'b0;
            ill_q    <= 1'b0;
            instr_q  <= '0;
            pc_q     <= '0;
            stall_q  <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            valid_q <= pop;
            rob_q   <= pop;
            rs_q    <= pop && (head_info.cls == CLS_RS);
            lsb_q   <= pop && (head_info.cls == CLS_LSB);
            if (pop) begin
                instr_q  <= head_instr;
                pc_q     <= head_pc;
                rready_q <= (head_info.cls == CLS_ROB);
                ill_q    <= head_info.illegal;
            end
            if (run && nonempty && !pop && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign issue_valid = valid_q;
    assign issue_instr = instr_q;
    assign issue_pc    = pc_q;
    assign rob_issue   = rob_q;
    assign rs_issue    = rs_q;
    assign lsb_issue   = lsb_q;
    assign rob_ready   = rready_q;
    assign illegal     = ill_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: a vector table for single-instruction
// flows plus hand-written sequences for full queue, flush, rdy_in hold
// and mid-operation reset.
module tb_dispatch_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, if_valid, flush_in, rob_full, rs_full, lsb_full;
    logic [31:0] if_instr, if_pc;
    logic        iq_ready, issue_valid, rob_issue, rs_issue, lsb_issue, rob_ready, illegal;
    logic [31:0] issue_instr, issue_pc;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    dispatch_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .iq_ready(iq_ready), .flush_in(flush_in),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_pc(issue_pc),
        .rob_issue(rob_issue), .rs_issue(rs_issue), .lsb_issue(lsb_issue),
        .rob_ready(rob_ready), .illegal(illegal), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        v;
        logic [31:0] instr, pc;
        logic        lsbf;
        logic        ev, erob, ers, elsb, err, eill;
        logic [31:0] einstr, epc;
        logic [15:0] estall;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic v, logic [31:0] instr, logic [31:0] pc, logic lsbf,
                                logic ev, logic erob, logic ers, logic elsb, logic err,
                                logic eill, logic [31:0] einstr, logic [31:0] epc,
                                logic [15:0] estall);
        vec_t r;
        r.v = v; r.instr = instr; r.pc = pc; r.lsbf = lsbf;
        r.ev = ev; r.erob = erob; r.ers = ers; r.elsb = elsb; r.err = err; r.eill = eill;
        r.einstr = einstr; r.epc = epc; r.estall = estall;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_valid = v; if_instr = instr; if_pc = pc;
    endtask

    logic [31:0] exp_i;

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        repeat (2) step();
        chk("rst_valid", {31'b0, issue_valid}, 32'd0);
        chk("rst_strobes", {29'b0, rob_issue, rs_issue, lsb_issue}, 32'd0);
        chk("rst_rr_ill", {30'b0, rob_ready, illegal}, 32'd0);
        chk("rst_instr", issue_instr, 32'h0);
        chk("rst_pc", issue_pc, 32'h0);
        chk("rst_stall", {16'b0, stall_cnt}, 32'd0);
        #3 rst_in = 1'b1;
        #1 chk("rst_iq_ready", {31'b0, iq_ready}, 32'd1);

        //        v  instr         pc     lsbf ev rob rs lsb rr ill einstr       epc    stall
        tbl[0]  = mk(1, 32'h00100093, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, 16'd0);
        tbl[1]  = mk(0, 32'h0,        32'h0, 0, 1, 1, 1, 0, 0, 0, 32'h00100093, 32'h0, 16'd0);
        tbl[2]  = mk(0, 32'h0,        32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, 16'd0);
        tbl[3]  = mk(1, 32'h0000A103, 32'h4, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, 16'd0);
        tbl[4]  = mk(0, 32'h0,        32'h0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, 16'd1);
        tbl[5]  = mk(0, 32'h0,        32'h0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, 16'd2);
        tbl[6]  = mk(0, 32'h0,        32'h0, 0, 1, 1, 0, 1, 0, 0, 32'h0000A103, 32'h4, 16'd2);
        tbl[7]  = mk(0, 32'h0,        32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, 16'd2);
        tbl[8]  = mk(1, 32'h123450B7, 32'h8, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, 16'd2);
        tbl[9]  = mk(1, 32'hFFFFFFFF, 32'hC, 0, 1, 1, 0, 0, 1, 0, 32'h123450B7, 32'h8, 16'd2);
        tbl[10] = mk(0, 32'h0,        32'h0, 0, 1, 1, 0, 0, 1, 1, 32'hFFFFFFFF, 32'hC, 16'd2);
        tbl[11] = mk(0, 32'h0,        32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, 16'd2);

        for (int i = 0; i < 12; i++) begin
            offer(tbl[i].v, tbl[i].instr, tbl[i].pc);
            lsb_full = tbl[i].lsbf;
            step();
            chk($sformatf("v%0d_valid", i), {31'b0, issue_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("v%0d_strobes", i), {29'b0, rob_issue, rs_issue, lsb_issue},
                {29'b0, tbl[i].erob, tbl[i].ers, tbl[i].elsb});
            chk($sformatf("v%0d_stall", i), {16'b0, stall_cnt}, {16'b0, tbl[i].estall});
            chk($sformatf("v%0d_iq_ready", i), {31'b0, iq_ready}, 32'd1);
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_instr", i), issue_instr, tbl[i].einstr);
                chk($sformatf("v%0d_pc", i), issue_pc, tbl[i].epc);
                chk($sformatf("v%0d_rr_ill", i), {30'b0, rob_ready, illegal},
                    {30'b0, tbl[i].err, tbl[i].eill});
            end
        end
        offer(1'b0, 32'h0, 32'h0);
        lsb_full = 1'b0;

        // Full queue: four accepted under rob_full, fifth refused, drain in order.
        rob_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 32'h00000013 | (i << 7), 32'h100 + 4 * i);
            step();
        end
        chk("full_iq_ready", {31'b0, iq_ready}, 32'd0);
        chk("full_stall", {16'b0, stall_cnt}, 32'd5);
        offer(1'b1, 32'h00000513, 32'h200);
        step();
        chk("full_no_issue", {31'b0, issue_valid}, 32'd0);
        chk("full_stall2", {16'b0, stall_cnt}, 32'd6);
        offer(1'b0, 32'h0, 32'h0);
        rob_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_i = 32'h00000013 | (i << 7);
            chk($sformatf("drain%0d_valid", i), {31'b0, issue_valid}, 32'd1);
            chk($sformatf("drain%0d_instr", i), issue_instr, exp_i);
            chk($sformatf("drain%0d_pc", i), issue_pc, 32'h100 + 4 * i);
        end
        step();
        chk("drain_done", {31'b0, issue_valid}, 32'd0);
        chk("drain_stall", {16'b0, stall_cnt}, 32'd6);

        // Flush with three queued entries and a simultaneous push.
        rob_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 32'h00000093, 32'h300 + 4 * i);
            step();
        end
        offer(1'b1, 32'h00000113, 32'h30C);
        flush_in = 1'b1;
        step();
        chk("flush_iq_ready", {31'b0, iq_ready}, 32'd0);
        chk("flush_no_issue", {31'b0, issue_valid}, 32'd0);
        flush_in = 1'b0;
        rob_full = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        step();
        chk("post_flush_iq_ready", {31'b0, iq_ready}, 32'd1);
        chk("post_flush_no_issue", {31'b0, issue_valid}, 32'd0);
        step();
        chk("post_flush_empty", {31'b0, issue_valid}, 32'd0);
        // Blocked-head cycles 2 and 3 of the fill plus the flush edge itself.
        chk("post_flush_stall", {16'b0, stall_cnt}, 32'd9);

        // rdy_in low with a poppable head: everything holds.
        rob_full = 1'b1;
        offer(1'b1, 32'h00000233, 32'h400);
        step();
        offer(1'b0, 32'h0, 32'h0);
        rob_full = 1'b0;
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold%0d_valid", i), {31'b0, issue_valid}, 32'd0);
            chk($sformatf("hold%0d_iq_ready", i), {31'b0, iq_ready}, 32'd0);
            chk($sformatf("hold%0d_stall", i), {16'b0, stall_cnt}, 32'd9);
        end
        rdy_in = 1'b1;
        step();
        chk("resume_valid", {31'b0, issue_valid}, 32'd1);
        chk("resume_instr", issue_instr, 32'h00000233);
        chk("resume_rs", {31'b0, rs_issue}, 32'd1);

        // Mid-operation reset discards a queued entry and clears the counter.
        rob_full = 1'b1;
        offer(1'b1, 32'h00000333, 32'h500);
        step();
        offer(1'b0, 32'h0, 32'h0);
        #2 rst_in = 1'b0;
        #2 rst_in = 1'b1;
        rob_full = 1'b0;
        step();
        chk("rst_mid_no_issue", {31'b0, issue_valid}, 32'd0);
        step();
        chk("rst_mid_no_issue2", {31'b0, issue_valid}, 32'd0);
        chk("rst_mid_stall", {16'b0, stall_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
